// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter.
//   - ALU mode codes as the shared ALU decodes them
//   - FSM state encoding
//   - alu_lat():     EXEC cycles for a mode
//   - alu_illegal(): modes above POW have no ALU meaning
package alu_arb_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_MUL   = 4'b0110;
  localparam logic [3:0] ALU_DIV   = 4'b0111;
  localparam logic [3:0] ALU_POW   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic alu_illegal(input logic [3:0] mode);
    return (mode > ALU_POW);
  endfunction

  // Multi-cycle units (MUL/DIV/POW) take multi_lat cycles, everything
  // else, including illegal codes, completes in one.
  function automatic logic [3:0] alu_lat(input logic [3:0] mode,
                                         input logic [3:0] multi_lat);
    logic [3:0] lat;
    lat = 4'd1;
    if (mode == ALU_MUL || mode == ALU_DIV || mode == ALU_POW)
      lat = multi_lat;
    return lat;
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// alu_arb_grant: combinational two-way grant.
// Build option: ALU_ARB_ROUND_ROBIN_EN
//   defined   - on a conflict the port not granted last wins
//   undefined - port 0 always wins a conflict, last_gnt is ignored
// Ports:
//   req0_valid, req1_valid  in   request present per port
//   last_gnt                in   port granted on the previous accept
//   gnt0, gnt1              out  one-hot (or zero) grant
module alu_arb_grant (
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic last_gnt,
  output logic gnt0,
  output logic gnt1
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Conflict goes to port 0 when port 1 was last, and vice versa.
  assign gnt0 = req0_valid & (~req1_valid | last_gnt);
  assign gnt1 = req1_valid & (~req0_valid | ~last_gnt);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid & ~req0_valid;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 64-bit ALU between two requesters (port 0 EX
// stage, port 1 address/branch unit). One op in flight at a time:
// IDLE accepts a request, EXEC holds the ALU inputs for the op latency,
// RESP presents the captured result to the originating port.
// Build option: ALU_ARB_ROUND_ROBIN_EN (round-robin instead of fixed
// port-0 priority; adds the last-grant pointer flop).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   reqN_valid/ready/mode/a/b      request handshake + payload
//   rspN_valid/ready               response handshake
//   rsp_result, rsp_zero           shared result and its zero flag
//   alu_mode, alu_a, alu_b         drive to the ALU
//   alu_out                        ALU result
//   busy                           state != IDLE
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int MULTI_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_mode,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_mode,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic [3:0]  alu_mode,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_out,
  output logic        busy
);

  localparam logic [3:0] MLAT = 4'(MULTI_LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  mode_q, mode_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic        id_q, id_d;
  logic [63:0] result_q, result_d;
  logic        zero_q, zero_d;

  logic        gnt0, gnt1, last_gnt, accept;
  logic [3:0]  sel_mode;
  logic [63:0] cap;

  alu_arb_grant u_grant (
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .last_gnt   (last_gnt),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign accept = (state_q == IDLE) & (gnt0 | gnt1);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (accept) last_d = gnt1;
  end

  // Reset to "port 1 last" so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign last_gnt = last_q;
`else
  assign last_gnt = 1'b1;
`endif

  assign sel_mode = gnt1 ? req1_mode : req0_mode;
  assign cap      = alu_illegal(mode_q) ? 64'd0 : alu_out;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = sel_mode;
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          id_d    = gnt1;
          cnt_d   = alu_lat(sel_mode, MLAT) - 4'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = cap;
          zero_d   = (cap == 64'd0);
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mode_q   <= ALU_PASSB;
      a_q      <= 64'd0;
      b_q      <= 64'd0;
      id_q     <= 1'b0;
      result_q <= 64'd0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Ready is gated by rst_n so it stays low while reset is asserted even
  // if a requester is already presenting valid.
  assign req0_ready = rst_n & (state_q == IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == IDLE) & gnt1;

  assign rsp0_valid = (state_q == RESP) & ~id_q;
  assign rsp1_valid = (state_q == RESP) &  id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

  // The ALU sees a quiet PASS-B of zero whenever no op is executing.
  assign alu_mode = (state_q == EXEC) ? mode_q : ALU_PASSB;
  assign alu_a    = (state_q == EXEC) ? a_q    : 64'd0;
  assign alu_b    = (state_q == EXEC) ? b_q    : 64'd0;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_mode, req1_mode;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  alu_mode;
  logic [63:0] alu_a, alu_b, alu_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          port;
    logic [63:0] res;
    logic        zero;
  } exp_t;
  exp_t sb[$];

  alu_arbiter #(.MULTI_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU; unknown codes return junk
  // so the arbiter's forced-zero on illegal modes is visible.
  always_comb begin
    alu_out = 64'hDEADBEEF;
    case (alu_mode)
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_PASSB: alu_out = alu_b;
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_MUL:   alu_out = alu_a * alu_b;
      ALU_DIV:   alu_out = (alu_b != 0) ? alu_a / alu_b : 64'd0;
      ALU_POW:   alu_out = alu_a * alu_a;
      default:   alu_out = 64'hDEADBEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    total++;
    assert (cond) else begin
      bad++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  // Pop the oldest expected response and compare against the live outputs.
  task automatic check_rsp();
    exp_t e;
    chk_true("sb_nonempty", sb.size() > 0);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("rsp_port", {rsp1_valid, rsp0_valid}, (e.port == 0) ? 2'b01 : 2'b10);
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_zero", rsp_zero, e.zero);
  endtask

  // Called just after a negedge; leaves the request up until it is
  // accepted, then returns at the first EXEC negedge with valid dropped.
  task automatic send(input int port, input logic [3:0] m, input logic [63:0] a,
                      input logic [63:0] b);
    bit ok = 0;
    if (port == 0) begin
      req0_valid = 1; req0_mode = m; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_mode = m; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) ok = 1;
      else @(negedge clk);
    end
    chk_true("accept_timeout", ok);
    @(negedge clk);
    if (port == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // Counts EXEC cycles (ALU inputs checked each one) until a response shows.
  task automatic wait_rsp(input int exp_lat, input logic [3:0] m, input logic [63:0] a,
                          input logic [63:0] b);
    int n = 0;
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (rsp0_valid || rsp1_valid) got = 1;
      else begin
        chk("exec_mode", alu_mode, m);
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_readies", {req1_ready, req0_ready}, 2'b00);
        n++;
        @(negedge clk);
      end
    end
    chk_true("rsp_timeout", got);
    if (!got) return;
    chk("exec_cycles", n, exp_lat);
    check_rsp();
    @(negedge clk);
    #1;
    chk("rsp_dropped", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    int eg[$];
    int r0, r1, ngr, nrs, gp;

    rst_n = 0;
    req0_valid = 1; req0_mode = ALU_ADD; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_mode = ALU_ADD; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // reset values, including ready low while a valid is already presented
    #3;
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_zero", rsp_zero, 1'b0);
    chk("rst_mode", alu_mode, ALU_PASSB);
    chk("rst_ab", {alu_a, alu_b}, 128'd0);
    chk("rst_busy", busy, 1'b0);
    req0_valid = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // port 0 ADD 5+7
    send(0, ALU_ADD, 64'd5, 64'd7);
    sb.push_back('{0, 64'd12, 1'b0});
    wait_rsp(1, ALU_ADD, 64'd5, 64'd7);

    // port 1 MUL 3*4, port 0 waits behind it
    send(1, ALU_MUL, 64'd3, 64'd4);
    sb.push_back('{1, 64'd12, 1'b0});
    req0_valid = 1; req0_mode = ALU_ADD; req0_a = 64'd1; req0_b = 64'd1;
    wait_rsp(4, ALU_MUL, 64'd3, 64'd4);
    send(0, ALU_ADD, 64'd1, 64'd1);
    sb.push_back('{0, 64'd2, 1'b0});
    wait_rsp(1, ALU_ADD, 64'd1, 64'd1);

    // conflict: both ports want two SUB 9-9
`ifdef ALU_ARB_ROUND_ROBIN_EN
    eg = '{0, 1, 0, 1};
`else
    eg = '{0, 0, 1, 1};
`endif
    r0 = 2; r1 = 2; ngr = 0; nrs = 0;
    for (int g = 0; g < 100 && nrs < 4; g++) begin
      req0_valid = (r0 > 0); req0_mode = ALU_SUB; req0_a = 64'd9; req0_b = 64'd9;
      req1_valid = (r1 > 0); req1_mode = ALU_SUB; req1_a = 64'd9; req1_b = 64'd9;
      #1;
      if (rsp0_valid || rsp1_valid) begin
        check_rsp();
        nrs++;
      end
      if (req0_ready || req1_ready) begin
        gp = req1_ready ? 1 : 0;
        chk("grant_onehot", req0_ready & req1_ready, 1'b0);
        if (ngr < eg.size()) chk("grant_order", gp, eg[ngr]);
        sb.push_back('{gp, 64'd0, 1'b1});
        if (gp == 0) r0--; else r1--;
        ngr++;
      end
      @(negedge clk);
    end
    chk("conflict_rsps", nrs, 4);
    req0_valid = 0; req1_valid = 0;
    sb.delete();

    // illegal mode forces a zero result
    send(0, 4'b1010, 64'd3, 64'd4);
    sb.push_back('{0, 64'd0, 1'b1});
    wait_rsp(1, 4'b1010, 64'd3, 64'd4);

    // held response blocks port 1 until the cycle after the handshake
    send(0, ALU_XOR, 64'hF0, 64'hFF);
    sb.push_back('{0, 64'h0F, 1'b0});
    rsp0_ready = 0;
    req1_valid = 1; req1_mode = ALU_ADD; req1_a = 64'd1; req1_b = 64'd2;
    @(negedge clk);
    #1;
    check_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp0_valid, 1'b1);
      chk("hold_result", rsp_result, 64'h0F);
      chk("hold_r1ready", req1_ready, 1'b0);
      @(negedge clk);
      #1;
    end
    rsp0_ready = 1;
    #1;
    chk("hs_r1ready", req1_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("post_hs_rspv", rsp0_valid, 1'b0);
    chk("post_hs_r1ready", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 0;
    sb.push_back('{1, 64'd3, 1'b0});
    wait_rsp(1, ALU_ADD, 64'd1, 64'd2);

    // reset mid-DIV: outputs clear without a clock, no response follows
    send(0, ALU_DIV, 64'd100, 64'd5);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_mode", alu_mode, ALU_PASSB);
    chk("arst_ab", {alu_a, alu_b}, 128'd0);
    chk("arst_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("arst_result", rsp_result, 64'd0);
    chk("arst_zero", rsp_zero, 1'b0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("no_div_rsp", {rsp1_valid, rsp0_valid, busy}, 3'b000);
    end
    send(0, ALU_ADD, 64'd20, 64'd22);
    sb.push_back('{0, 64'd42, 1'b0});
    wait_rsp(1, ALU_ADD, 64'd20, 64'd22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
